iter_shift: RTL and testbench

ITER_SHIFT -- requirements
Module: iter_shift

---
 rtl/iter_shift.sv | 101 ++++++++++
 tb/tb_iter_shift.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift.sv
// Iterative shifter: applies a one-bit shift/rotate per clock until the captured
// shift amount is consumed, then pulses done for one cycle.
module iter_shift #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] ModeLsr = 2'b00;
  localparam logic [1:0] ModeLsl = 2'b01;
  localparam logic [1:0] ModeAsr = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (shamt != '0) ? StShift : StDone;
      StShift: if (cnt_q == SHAMT_W'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
  end

  // One-bit step of the captured operation.
  always_comb begin
    step = data_q;
    unique case (mode_q)
      ModeLsr: step = {1'b0, data_q[WIDTH-1:1]};
      ModeLsl: step = {data_q[WIDTH-2:0], 1'b0};
      ModeAsr: step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      ModeRor: step = {data_q[0], data_q[WIDTH-1:1]};
      default: step = data_q;
    endcase
  end

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d = in_data;
          mode_d = mode;
          cnt_d  = shamt;
        end
      end
      StShift: begin
        data_d = step;
        // cnt_q is always >= 1 here; guard anyway so it can never wrap.
        if (cnt_q != '0) cnt_d = cnt_q - SHAMT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= 2'b00;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_iter_shift.sv
// Scoreboard bench for iter_shift (WIDTH=8): stimulus pushes expected results,
// a monitor pops and checks them whenever done is presented.
module tb_iter_shift;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHAMT_W = 3;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   out_data;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  iter_shift #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .in_data (in_data),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: counts busy cycles per operation and checks each done against the queue.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy && done) begin
          errors++;
          $display("FAIL busy_done_exclusive: busy=%0b done=%0b, required not both high", busy, done);
        end
        if (busy) busy_cnt++;
        if (done) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done with out_data=%h, required no done", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data) begin
              errors++;
              $display("FAIL result: out_data=%h, required %h", out_data, e.data);
            end
            checks++;
            if (busy_cnt != e.busy_cycles) begin
              errors++;
              $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, e.busy_cycles);
            end
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one start pulse; accepted on the following rising edge.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                       input logic [1:0] m, input bit push, input logic [WIDTH-1:0] exp_data);
    exp_t e;
    @(posedge clk);
    #1;
    start   = 1'b1;
    in_data = d;
    shamt   = s;
    mode    = m;
    if (push) begin
      e.data        = exp_data;
      e.busy_cycles = int'(s);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns at the falling edge of the done cycle; optionally checks the result is held.
  task automatic wait_done(input bit check_hold, input logic [WIDTH-1:0] exp_data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done not seen within 40 cycles, required done");
    end else if (check_hold) begin
      repeat (2) @(negedge clk);
      check("result_held", out_data, exp_data);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 2'b00;
    in_data = '0;
    shamt   = '0;
    #1;
    check("reset_out_data", out_data, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    check("reset_done", {7'b0, done}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Four modes on 0xB4, shift by 3.
    issue(8'hB4, 3'd3, 2'b00, 1'b1, 8'h16); wait_done(1'b1, 8'h16);
    issue(8'hB4, 3'd3, 2'b10, 1'b1, 8'hF6); wait_done(1'b1, 8'hF6);
    issue(8'hB4, 3'd3, 2'b01, 1'b1, 8'hA0); wait_done(1'b1, 8'hA0);
    issue(8'hB4, 3'd3, 2'b11, 1'b1, 8'h96); wait_done(1'b1, 8'h96);

    // Zero shift in every mode: no busy, done one cycle after accept.
    for (int m = 0; m < 4; m++) begin
      issue(8'h5A, 3'd0, m[1:0], 1'b1, 8'h5A);
      wait_done(1'b1, 8'h5A);
    end

    // Maximum shift with start pulses and operand changes during busy.
    issue(8'h81, 3'd7, 2'b11, 1'b1, 8'h03);
    @(posedge clk);
    #1;
    start   = 1'b1;
    in_data = 8'hFF;
    shamt   = 3'd2;
    mode    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b1, 8'h03);

    // Reset mid-shift aborts without done; start held through release.
    issue(8'hFF, 3'd5, 2'b00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_data", out_data, 8'h00);
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_done", {7'b0, done}, 8'h00);
    start   = 1'b1;
    in_data = 8'h80;
    shamt   = 3'd1;
    mode    = 2'b10;
    begin
      exp_t e;
      e.data        = 8'hC0;
      e.busy_cycles = 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b1, 8'hC0);

    // Back-to-back: second start asserted in the idle cycle right after done.
    issue(8'h3C, 3'd2, 2'b01, 1'b1, 8'hF0);
    wait_done(1'b0, 8'h00);
    issue(8'hC3, 3'd4, 2'b10, 1'b1, 8'hFC);
    wait_done(1'b1, 8'hFC);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
